// File: rtl/pipe_stage_regs_pkg.sv
// Shared constants for the fetch/decode/execute pipeline registers.
// Ports: none (package). Holds the NOP encoding, the bubble control word,
// control-bundle field offsets and the default reset PC.
package pipe_stage_regs_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [15:0] CTRL_BUBBLE      = 16'h0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Control bundle layout (bit offsets inside ctrl_D / ctrl_E)
  localparam int CTRL_REGWRITE     = 0;
  localparam int CTRL_RESULTSRC_LO = 1;  // 2 bits
  localparam int CTRL_MEMWRITE     = 3;
  localparam int CTRL_JUMP         = 4;
  localparam int CTRL_BRANCH       = 5;
  localparam int CTRL_ALUSRC       = 6;
  localparam int CTRL_ALUCTRL_LO   = 7;  // 3 bits

  // Packs individual decode fields into a control bundle.
  function automatic logic [15:0] make_ctrl(input logic       reg_write,
                                            input logic [1:0] result_src,
                                            input logic       mem_write,
                                            input logic       jump,
                                            input logic       branch,
                                            input logic       alu_src,
                                            input logic [2:0] alu_ctrl);
    logic [15:0] c;
    c = CTRL_BUBBLE;
    c[CTRL_REGWRITE]                            = reg_write;
    c[CTRL_RESULTSRC_LO +: 2]                   = result_src;
    c[CTRL_MEMWRITE]                            = mem_write;
    c[CTRL_JUMP]                                = jump;
    c[CTRL_BRANCH]                              = branch;
    c[CTRL_ALUSRC]                              = alu_src;
    c[CTRL_ALUCTRL_LO +: 3]                     = alu_ctrl;
    return c;
  endfunction

endpackage

// File: rtl/pipe_stage_regs_if.sv
// Bus between the hazard unit / datapath and the pipeline register block.
// Ports: stall/flush controls, redirect target, fetch instruction, decode-side
// operands in; fetch PC, IF/ID and ID/EX copies, event counters out.
interface pipe_stage_regs_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32
);
  // controls and fetch side
  logic              stall;
  logic              flush;
  logic [XLEN-1:0]   pc_target_E;
  logic [31:0]       instr_F;
  logic [XLEN-1:0]   pc_F;
  // IF/ID
  logic [31:0]       instr_D;
  logic [XLEN-1:0]   pc_D;
  logic [XLEN-1:0]   pcplus4_D;
  logic              valid_D;
  // decode-side inputs
  logic [CTRL_W-1:0] ctrl_D;
  logic [XLEN-1:0]   rd1_D, rd2_D, imm_D;
  logic [4:0]        rs1_D, rs2_D, rd_D;
  // ID/EX
  logic [CTRL_W-1:0] ctrl_E;
  logic [XLEN-1:0]   rd1_E, rd2_E, imm_E, pc_E, pcplus4_E;
  logic [4:0]        rs1_E, rs2_E, rd_E;
  logic              valid_E;
  // performance counters
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output stall, flush, pc_target_E, instr_F,
    output ctrl_D, rd1_D, rd2_D, imm_D, rs1_D, rs2_D, rd_D,
    input  pc_F, instr_D, pc_D, pcplus4_D, valid_D,
    input  ctrl_E, rd1_E, rd2_E, imm_E, pc_E, pcplus4_E, rs1_E, rs2_E, rd_E, valid_E,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  stall, flush, pc_target_E, instr_F,
    input  ctrl_D, rd1_D, rd2_D, imm_D, rs1_D, rs2_D, rd_D,
    output pc_F, instr_D, pc_D, pcplus4_D, valid_D,
    output ctrl_E, rd1_E, rd2_E, imm_E, pc_E, pcplus4_E, rs1_E, rs2_E, rd_E, valid_E,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_stage_regs_pipe_reg.sv
// Generic pipeline register with enable and synchronous clear.
// Ports: clk, rst (sync, active-high), en (load d), clr (load CLR_VAL), d, q.
// Reset and clear both load CLR_VAL; clear takes priority over enable.
module pipe_reg #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= CLR_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_regs.sv
// PC, IF/ID and ID/EX registers of the RV32I core with stall/flush handling.
// Ports: clk, rst (sync, active-high), bus (slave side of pipe_stage_regs_if).
// Priority rst > flush > stall > advance; saturating stall/flush event counters.
module pipe_stage_regs
  import pipe_stage_regs_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              CTRL_W   = 16,
  parameter int              CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  pipe_stage_regs_if.slave  bus
);

  localparam int IFID_W = 32 + 2 * XLEN + 1;
  localparam int IDEX_W = CTRL_W + 5 * XLEN + 15 + 1;

  localparam logic [IFID_W-1:0] IFID_BUBBLE = {NOP_INSTR, {(2 * XLEN + 1){1'b0}}};
  // Bubble zeroes register indices too, so forwarding/load-use compares never
  // match a stale destination.
  localparam logic [IDEX_W-1:0] IDEX_BUBBLE = {CTRL_W'(CTRL_BUBBLE), {(IDEX_W - CTRL_W){1'b0}}};

  // ---------------- PC ----------------
  logic [XLEN-1:0] pc_q, pc_plus4, pc_next;

  assign pc_plus4 = pc_q + XLEN'(4);
  assign pc_next  = bus.flush ? bus.pc_target_E : pc_plus4;

  // Flush must redirect even when a stall is requested the same cycle.
  pipe_reg #(.WIDTH(XLEN), .CLR_VAL(RESET_PC)) u_pc (
    .clk (clk),
    .rst (rst),
    .en  (bus.flush | ~bus.stall),
    .clr (1'b0),
    .d   (pc_next),
    .q   (pc_q)
  );

  // ---------------- IF/ID ----------------
  logic [IFID_W-1:0] ifid_q;
  logic [31:0]       instr_D;
  logic [XLEN-1:0]   pc_D, pcplus4_D;
  logic              valid_D;

  pipe_reg #(.WIDTH(IFID_W), .CLR_VAL(IFID_BUBBLE)) u_ifid (
    .clk (clk),
    .rst (rst),
    .en  (~bus.stall),
    .clr (bus.flush),
    .d   ({bus.instr_F, pc_q, pc_plus4, 1'b1}),
    .q   (ifid_q)
  );

  assign {instr_D, pc_D, pcplus4_D, valid_D} = ifid_q;

  // ---------------- ID/EX ----------------
  logic [IDEX_W-1:0] idex_q;

  pipe_reg #(.WIDTH(IDEX_W), .CLR_VAL(IDEX_BUBBLE)) u_idex (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .clr (bus.flush | bus.stall),
    .d   ({bus.ctrl_D, bus.rd1_D, bus.rd2_D, bus.imm_D, pc_D, pcplus4_D,
           bus.rs1_D, bus.rs2_D, bus.rd_D, valid_D}),
    .q   (idex_q)
  );

  // ---------------- event counters ----------------
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (bus.flush) begin
      if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end else if (bus.stall) begin
      if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // ---------------- outputs ----------------
  assign bus.pc_F      = pc_q;
  assign bus.instr_D   = instr_D;
  assign bus.pc_D      = pc_D;
  assign bus.pcplus4_D = pcplus4_D;
  assign bus.valid_D   = valid_D;
  assign {bus.ctrl_E, bus.rd1_E, bus.rd2_E, bus.imm_E, bus.pc_E, bus.pcplus4_E,
          bus.rs1_E, bus.rs2_E, bus.rd_E, bus.valid_E} = idex_q;
  assign bus.stall_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;

endmodule
